// File: rtl/mlp_pkg.sv
// Shared types and arithmetic helpers for the time-multiplexed perceptron trainer.
package mlp_pkg;

  typedef enum logic [2:0] {IDLE, FWD_HID, FWD_OUT, LOSS, UPDATE, DONE} state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int out_w(input int hid_w, input int ww, input int n_hid);
    return hid_w + ww + $clog2(n_hid) + 1;
  endfunction

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Clamp to the two's-complement range of a ww-bit weight.
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] v, input int ww);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (ww - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ww - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic signed [63:0] relu_sat(input logic signed [63:0] v, input int hid_w);
    logic signed [63:0] hi;
    hi = (64'sd1 <<< hid_w) - 64'sd1;
    if (v < 64'sd0) return 64'sd0;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/mlp_trainer_if.sv
// Pass handshake, weight write port and result bus of mlp_trainer.
interface mlp_trainer_if #(
  parameter int N_IN  = 4,
  parameter int N_HID = 8,
  parameter int XW    = 4,
  parameter int WW    = 8,
  parameter int HID_W = 10
);
  localparam int OW = mlp_pkg::out_w(HID_W, WW, N_HID);
  localparam int HW = mlp_pkg::idx_w(N_HID);
  localparam int IW = mlp_pkg::idx_w(N_IN);

  logic                   start_i;
  logic                   train_i;
  logic [N_IN*XW-1:0]     x_i;
  logic signed [OW-1:0]   target_i;
  logic                   wr_en_i;
  logic                   wr_sel_i;
  logic [HW-1:0]          wr_hid_i;
  logic [IW-1:0]          wr_in_i;
  logic signed [WW-1:0]   wr_data_i;
  logic                   busy_o;
  logic                   done_o;
  logic signed [OW-1:0]   final_o;
  logic signed [OW:0]     err_o;

  modport master (
    output start_i, train_i, x_i, target_i, wr_en_i, wr_sel_i, wr_hid_i, wr_in_i, wr_data_i,
    input  busy_o, done_o, final_o, err_o
  );

  modport slave (
    input  start_i, train_i, x_i, target_i, wr_en_i, wr_sel_i, wr_hid_i, wr_in_i, wr_data_i,
    output busy_o, done_o, final_o, err_o
  );
endinterface

// File: rtl/mlp_trainer_mac_unit.sv
// Signed multiply-accumulate; sum_o is the value the accumulator takes on an enabled edge.
module mac_unit #(
  parameter int AW   = 11,
  parameter int BW   = 23,
  parameter int ACCW = 34
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   en_i,
  input  logic signed [AW-1:0]   a_i,
  input  logic signed [BW-1:0]   b_i,
  output logic signed [ACCW-1:0] sum_o
);
  logic signed [ACCW-1:0] acc_q, a_ext, b_ext, base;

  assign a_ext = ACCW'(a_i);
  assign b_ext = ACCW'(b_i);
  assign base  = clr_i ? '0 : acc_q;
  assign sum_o = base + a_ext * b_ext;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     acc_q <= '0;
    else if (en_i) acc_q <= sum_o;
  end
endmodule

// File: rtl/mlp_trainer.sv
// Two-layer perceptron with one shared MAC: forward pass, loss and output-weight update.
module mlp_trainer import mlp_pkg::*; #(
  parameter int N_IN     = 4,
  parameter int N_HID    = 8,
  parameter int XW       = 4,
  parameter int WW       = 8,
  parameter int HID_W    = 10,
  parameter int LR_SHIFT = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  mlp_trainer_if.slave bus
);
  localparam int OW   = out_w(HID_W, WW, N_HID);
  localparam int EW   = OW + 1;
  localparam int HW   = idx_w(N_HID);
  localparam int IW   = idx_w(N_IN);
  localparam int AW   = max_w(XW, HID_W) + 1;
  localparam int BW   = EW;
  localparam int ACCW = AW + BW;

  state_e                state_q;
  logic [HW-1:0]         h_q;
  logic [IW-1:0]         i_q;
  logic                  train_q, busy_q, done_q;
  logic [XW-1:0]         x_q [N_IN];
  logic signed [OW-1:0]  target_q, final_q;
  logic signed [EW-1:0]  err_q;
  logic signed [WW-1:0]  wh_q [N_HID][N_IN];
  logic signed [WW-1:0]  wo_q [N_HID];
  logic [HID_W-1:0]      hid_q [N_HID];

  logic                  mac_clr, mac_en, last_i, last_h;
  logic signed [AW-1:0]  mac_a;
  logic signed [BW-1:0]  mac_b;
  logic signed [ACCW-1:0] mac_sum;
  logic [HID_W-1:0]      hid_new;
  logic signed [WW-1:0]  wo_upd;

  assign last_i  = (i_q == IW'(N_IN - 1));
  assign last_h  = (h_q == HW'(N_HID - 1));
  assign hid_new = HID_W'(relu_sat(64'(mac_sum), HID_W));
  // During UPDATE the MAC is cleared every cycle, so mac_sum is exactly err*hid[h].
  assign wo_upd  = WW'(sat_w(64'(wo_q[h_q]) - 64'(mac_sum >>> LR_SHIFT), WW));

  always_comb begin
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    mac_a   = '0;
    mac_b   = '0;
    case (state_q)
      FWD_HID: begin
        mac_en  = 1'b1;
        mac_clr = (i_q == '0);
        mac_a   = signed'(AW'(x_q[i_q]));
        mac_b   = BW'(wh_q[h_q][i_q]);
      end
      FWD_OUT: begin
        mac_en  = 1'b1;
        mac_clr = (h_q == '0);
        mac_a   = signed'(AW'(hid_q[h_q]));
        mac_b   = BW'(wo_q[h_q]);
      end
      UPDATE: begin
        mac_en  = 1'b1;
        mac_clr = 1'b1;
        mac_a   = signed'(AW'(hid_q[h_q]));
        mac_b   = err_q;
      end
      default: ;
    endcase
  end

  mac_unit #(.AW(AW), .BW(BW), .ACCW(ACCW)) u_mac (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(mac_clr), .en_i(mac_en),
    .a_i(mac_a), .b_i(mac_b), .sum_o(mac_sum)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      h_q      <= '0;
      i_q      <= '0;
      train_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      target_q <= '0;
      final_q  <= '0;
      err_q    <= '0;
      for (int i = 0; i < N_IN; i++) x_q[i] <= '0;
      for (int h = 0; h < N_HID; h++) begin
        wo_q[h]  <= WW'(h + 1);
        hid_q[h] <= '0;
        for (int i = 0; i < N_IN; i++) wh_q[h][i] <= WW'(i + 1);
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.wr_en_i) begin
            if (bus.wr_sel_i) wo_q[bus.wr_hid_i] <= bus.wr_data_i;
            else              wh_q[bus.wr_hid_i][bus.wr_in_i] <= bus.wr_data_i;
          end
          if (bus.start_i) begin
            for (int i = 0; i < N_IN; i++) x_q[i] <= bus.x_i[i*XW +: XW];
            target_q <= bus.target_i;
            train_q  <= bus.train_i;
            h_q      <= '0;
            i_q      <= '0;
            busy_q   <= 1'b1;
            state_q  <= FWD_HID;
          end
        end
        FWD_HID: begin
          if (last_i) begin
            hid_q[h_q] <= hid_new;
            i_q        <= '0;
            if (last_h) begin
              h_q     <= '0;
              state_q <= FWD_OUT;
            end else begin
              h_q <= h_q + HW'(1);
            end
          end else begin
            i_q <= i_q + IW'(1);
          end
        end
        FWD_OUT: begin
          if (last_h) begin
            final_q <= OW'(mac_sum);
            h_q     <= '0;
            state_q <= LOSS;
          end else begin
            h_q <= h_q + HW'(1);
          end
        end
        LOSS: begin
          err_q <= EW'(final_q) - EW'(target_q);
          if (train_q) begin
            state_q <= UPDATE;
          end else begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        UPDATE: begin
          wo_q[h_q] <= wo_upd;
          if (last_h) begin
            h_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            h_q <= h_q + HW'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy_o  = busy_q;
  assign bus.done_o  = done_q;
  assign bus.final_o = final_q;
  assign bus.err_o   = err_q;
endmodule

// File: tb/tb_mlp_trainer.sv
// Directed and randomized passes through mlp_trainer checked against an arithmetic model.
module tb_mlp_trainer;
  localparam int N_IN  = 4;
  localparam int N_HID = 8;
  localparam int OW    = 22;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mlp_trainer_if bus ();
  mlp_trainer dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int nvec = 0;
  int nerr = 0;
  int wh [N_HID][N_IN];
  int wo [N_HID];
  int xv [N_IN];

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int h = 0; h < N_HID; h++) begin
      wo[h] = h + 1;
      for (int i = 0; i < N_IN; i++) wh[h][i] = i + 1;
    end
  endfunction

  task automatic model_pass(input bit tr, input longint tgt, output longint fin, output longint err);
    longint hid [N_HID];
    longint s;
    fin = 0;
    for (int h = 0; h < N_HID; h++) begin
      s = 0;
      for (int i = 0; i < N_IN; i++) s += longint'(xv[i] * wh[h][i]);
      hid[h] = (s < 0) ? 0 : ((s > 1023) ? 1023 : s);
      fin += hid[h] * wo[h];
    end
    err = fin - tgt;
    if (tr) begin
      for (int h = 0; h < N_HID; h++) begin
        s = wo[h] - ((err * hid[h]) >>> 8);
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        wo[h] = int'(s);
      end
    end
  endtask

  task automatic write_w(input bit sel, input int h, input int i, input int val);
    @(negedge clk);
    bus.wr_en_i   = 1'b1;
    bus.wr_sel_i  = sel;
    bus.wr_hid_i  = 3'(h);
    bus.wr_in_i   = 2'(i);
    bus.wr_data_i = 8'(val);
    if (sel) wo[h] = val;
    else     wh[h][i] = val;
    @(negedge clk);
    bus.wr_en_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // mode: 0 plain, 1 write+start while busy, 2 write in the start cycle, 3 reset at cycle 20
  task automatic run_pass(input bit tr, input longint tgt, input int mode, input string tag);
    longint fin, err;
    int cyc, exp_done;
    bit busy_ok;
    @(negedge clk);
    for (int i = 0; i < N_IN; i++) bus.x_i[i*4 +: 4] = 4'(xv[i]);
    bus.target_i = OW'(tgt);
    bus.train_i  = tr;
    bus.start_i  = 1'b1;
    if (mode == 2) begin
      bus.wr_en_i = 1'b1; bus.wr_sel_i = 1'b1; bus.wr_hid_i = 3'd2; bus.wr_data_i = 8'sd50;
      wo[2] = 50;
    end
    model_pass(tr, tgt, fin, err);
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.wr_en_i = 1'b0;
    cyc = 1;
    busy_ok = 1'b1;
    while (bus.done_o !== 1'b1 && cyc < 300) begin
      if (bus.busy_o !== 1'b1) busy_ok = 1'b0;
      if (mode == 1 && cyc == 10) begin
        bus.start_i = 1'b1; bus.train_i = ~tr;
        bus.wr_en_i = 1'b1; bus.wr_sel_i = 1'b1; bus.wr_hid_i = 3'd0; bus.wr_data_i = 8'sd99;
      end else if (mode == 1 && cyc == 11) begin
        bus.start_i = 1'b0; bus.wr_en_i = 1'b0;
      end
      if (mode == 3 && cyc == 20) begin
        rst = 1'b1;
        #1;
        chk({tag, "/busy_in_rst"}, bus.busy_o, 0);
        chk({tag, "/final_in_rst"}, bus.final_o, 0);
        chk({tag, "/err_in_rst"}, bus.err_o, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      @(negedge clk);
      cyc++;
    end
    exp_done = N_HID * N_IN + N_HID + 2 + (tr ? N_HID : 0);
    chk({tag, "/done_cycle"}, cyc, exp_done);
    chk({tag, "/busy_during"}, busy_ok, 1);
    chk({tag, "/busy_at_done"}, bus.busy_o, 0);
    chk({tag, "/final"}, bus.final_o, fin);
    chk({tag, "/err"}, bus.err_o, err);
    @(negedge clk);
    chk({tag, "/done_pulse"}, bus.done_o, 0);
  endtask

  initial begin
    bus.start_i = 1'b0; bus.train_i = 1'b0; bus.x_i = '0; bus.target_i = '0;
    bus.wr_en_i = 1'b0; bus.wr_sel_i = 1'b0; bus.wr_hid_i = '0; bus.wr_in_i = '0; bus.wr_data_i = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst/busy", bus.busy_o, 0);
    chk("rst/done", bus.done_o, 0);
    chk("rst/final", bus.final_o, 0);
    chk("rst/err", bus.err_o, 0);
    rst = 1'b0;

    xv = '{1, 1, 1, 1};
    run_pass(1'b0, 0, 0, "infer");
    chk("infer/final_360", bus.final_o, 360);
    chk("infer/err_360", bus.err_o, 360);
    run_pass(1'b1, 0, 0, "train");
    chk("train/final_360", bus.final_o, 360);
    run_pass(1'b0, 0, 0, "rerun");
    chk("rerun/final_m760", bus.final_o, -760);

    run_pass(1'b1, 0, 3, "rst_mid");
    run_pass(1'b0, 0, 0, "after_rst");
    chk("after_rst/final_360", bus.final_o, 360);

    xv = '{15, 15, 15, 15};
    run_pass(1'b1, 0, 0, "sat");
    chk("sat/final_5400", bus.final_o, 5400);
    xv = '{1, 1, 1, 1};
    run_pass(1'b0, 0, 0, "sat_wo");
    chk("sat_wo/final_clamped", bus.final_o, -10240);

    do_reset();
    for (int i = 0; i < N_IN; i++) write_w(1'b0, 0, i, -4);
    run_pass(1'b0, 0, 0, "relu");
    chk("relu/final_350", bus.final_o, 350);

    run_pass(1'b0, 77, 1, "disturbed");
    run_pass(1'b0, 77, 0, "undisturbed");
    run_pass(1'b1, 100, 2, "wr_at_start");

    for (int n = 0; n < 12; n++) begin
      int nw;
      nw = int'($urandom_range(0, 2));
      for (int k = 0; k < nw; k++)
        write_w(1'($urandom_range(0, 1)), int'($urandom_range(0, N_HID - 1)),
                int'($urandom_range(0, N_IN - 1)), int'($urandom_range(0, 255)) - 128);
      for (int i = 0; i < N_IN; i++) xv[i] = int'($urandom_range(0, 15));
      run_pass(1'($urandom_range(0, 1)), longint'(int'($urandom_range(0, 200000)) - 100000), 0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
